// File: rtl/bus_protocol_target_if.sv
// dValid/dAck byte bus plus the downstream valid/ready drain port.
//   master : bus master / consumer side (drives dValid, data, out_ready)
//   slave  : bus_protocol_target side (drives dAck, out_data, out_valid)
interface bus_protocol_target_if #(
  parameter int DATA_W = 8
);
  logic              dValid;
  logic [DATA_W-1:0] data;
  logic              dAck;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output dValid, data, out_ready, input dAck, out_data, out_valid);
  modport slave  (input dValid, data, out_ready, output dAck, out_data, out_valid);
endinterface

// File: rtl/bus_protocol_target.sv
// Target end of the dValid/dAck byte bus. Detects a transfer start, pulses
// dAck so it is sampled ACK_DELAY edges after the start edge (deferred while
// the FIFO is full, up to E3), captures the byte into a DEPTH-entry FIFO that
// drains over valid/ready, counts refused transfers and flags master errors.
// Ports:
//   clk, reset  clock, async active-low reset
//   bus         slave modport: dValid/data in, dAck out, out_* drain port
//   drop_cnt    saturating count of refused (nacked) transfers
//   proto_err   one-cycle pulse on a master protocol violation
module bus_protocol_target #(
  parameter int ACK_DELAY = 1,
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_protocol_target_if.slave bus,
  output logic [7:0]           drop_cnt,
  output logic                 proto_err
);
  localparam int         AW      = $clog2(DEPTH);
  localparam int         AI      = ACK_DELAY - 1;
  localparam logic [2:0] ACK_IDX = AI[2:0];
  localparam logic [AW:0] FULL   = DEPTH[AW:0];

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_ACKED   = 2'd2;
  localparam logic [1:0] S_WAITLOW = 2'd3;

  logic [1:0]        state;
  logic [2:0]        ecnt;      // index of the edge about to be sampled; saturates at 4
  logic              dv_q;      // dValid at the previous edge
  logic              nack;      // transfer refused, count it when dValid drops
  logic              hold_chk;  // first edge after the ack edge: dValid must be low
  logic              late_chk;  // unacked transfer: dValid must be low by E4
  logic [DATA_W-1:0] data_ref;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              full, push, pop, chg, err;

  assign full          = (cnt == FULL);
  assign push          = (state == S_ACKED);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = (cnt != '0);
  assign bus.out_data  = mem[rptr];
  assign chg           = (bus.data != data_ref);

  assign err = ((state == S_ARM)     && (!bus.dValid || chg)) ||
               ((state == S_ACKED)   && chg) ||
               ((state == S_WAITLOW) && bus.dValid && (hold_chk || (late_chk && ecnt[2])));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ecnt      <= '0;
      dv_q      <= 1'b1;  // dValid already high out of reset is not a start
      nack      <= 1'b0;
      hold_chk  <= 1'b0;
      late_chk  <= 1'b0;
      data_ref  <= '0;
      bus.dAck  <= 1'b0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      dv_q      <= bus.dValid;
      proto_err <= err;
      if (state != S_IDLE && !ecnt[2]) ecnt <= ecnt + 3'd1;
      case (state)
        S_IDLE: begin
          if (bus.dValid) begin
            if (!dv_q) begin
              data_ref <= bus.data;
              ecnt     <= 3'd1;
              if (ACK_DELAY == 1 && !full) begin
                bus.dAck <= 1'b1;
                state    <= S_ACKED;
              end else begin
                state <= S_ARM;
              end
            end else begin
              state <= S_WAITLOW;  // mid-transfer after reset: sit it out
            end
          end
        end
        S_ARM: begin
          // ref follows the bus so one data change yields one error pulse
          data_ref <= bus.data;
          if (!bus.dValid) begin
            state <= S_IDLE;
          end else if (ecnt >= ACK_IDX && !full) begin
            bus.dAck <= 1'b1;
            state    <= S_ACKED;
          end else if (ecnt >= 3'd2) begin
            nack     <= 1'b1;
            late_chk <= 1'b1;
            state    <= S_WAITLOW;
          end
        end
        S_ACKED: begin
          data_ref <= bus.data;
          bus.dAck <= 1'b0;
          hold_chk <= 1'b1;
          state    <= S_WAITLOW;
        end
        default: begin
          hold_chk <= 1'b0;
          if (late_chk && ecnt[2] && bus.dValid) late_chk <= 1'b0;
          if (!bus.dValid) begin
            state    <= S_IDLE;
            nack     <= 1'b0;
            late_chk <= 1'b0;
            if (nack && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.data;
  end
endmodule

// File: tb/tb_bus_protocol_target.sv
module tb_bus_protocol_target;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       dv  [3];
  logic       rdy [3];
  logic [7:0] dd  [3];
  logic       ack [3];
  logic       ov  [3];
  logic       pe  [3];
  logic [7:0] od  [3];
  logic [7:0] dc  [3];

  int n_chk = 0;
  int n_err = 0;

  // reference: per-instance FIFO contents and drop count, plus the outputs
  // expected right after the coming edge
  logic [7:0] mq [3][$];
  int         mdrop [3];
  bit         eack [3];
  bit         epe  [3];
  bit         push [3];

  bus_protocol_target_if #(.DATA_W(8)) bif [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bif[g].dValid    = dv[g];
    assign bif[g].data      = dd[g];
    assign bif[g].out_ready = rdy[g];
    assign ack[g] = bif[g].dAck;
    assign ov[g]  = bif[g].out_valid;
    assign od[g]  = bif[g].out_data;
    bus_protocol_target #(.ACK_DELAY(g + 1), .DEPTH(4), .DATA_W(8)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bif[g]),
      .drop_cnt  (dc[g]),
      .proto_err (pe[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: apply pops/pushes to the reference, then compare all instances
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (push[i]) mq[i].push_back(dd[i]);
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dAck[%0d]", i), 32'(ack[i]), 32'(eack[i]));
      chk($sformatf("proto_err[%0d]", i), 32'(pe[i]), 32'(epe[i]));
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(mq[i].size() > 0));
      chk($sformatf("drop_cnt[%0d]", i), 32'(dc[i]), 32'(mdrop[i]));
      if (mq[i].size() > 0) chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(mq[i][0]));
      eack[i] = 1'b0;
      epe[i]  = 1'b0;
      push[i] = 1'b0;
    end
  endtask

  // One master transfer on instance k (ACK_DELAY = k+1), out_ready held at r.
  // The ack is set at the first edge j in [ACK_DELAY-1, 2] where the FIFO
  // held fewer than 4 entries, and sampled at j+1; otherwise refused.
  // mode: 0 clean, 1 data change at E1, 2 dValid held 2 edges past the ack,
  //       3 abort at E1, 4 refused transfer still high at E4
  task automatic xfer(input int k, input logic [7:0] d, input logic r, input int mode);
    int a;
    int ae;
    bit given;
    a = k + 1;
    ae = -1;
    given = 1'b0;
    rdy[k] = r;
    dd[k]  = d;
    dv[k]  = 1'b1;
    for (int e = 0; e < 4; e++) begin
      if (mode == 1 && e == 1) begin
        dd[k]  = d + 8'd1;
        epe[k] = 1'b1;
      end
      if (mode == 3 && e == 1) begin
        dv[k]  = 1'b0;
        epe[k] = 1'b1;
        step();
        return;
      end
      if (!given && e >= a - 1 && e <= 2 && mq[k].size() < 4) begin
        eack[k] = 1'b1;
        given   = 1'b1;
        ae      = e + 1;
      end
      if (e == ae) push[k] = 1'b1;
      step();
      if (e == ae) break;
    end
    if (given && mode == 2) begin
      epe[k] = 1'b1;
      step();
      step();
    end
    if (!given && mode == 4) begin
      epe[k] = 1'b1;
      step();
    end
    dv[k] = 1'b0;
    if (!given && mdrop[k] < 255) mdrop[k]++;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
    repeat (5) step();
    for (int i = 0; i < 3; i++) rdy[i] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      dv[i] = 1'b0; rdy[i] = 1'b0; dd[i] = 8'h00;
      mdrop[i] = 0; eack[i] = 1'b0; epe[i] = 1'b0; push[i] = 1'b0;
    end
    // reset values
    step();
    step();
    reset = 1'b1;
    step();

    // basic ACK_DELAY=1 transfer, then pop
    xfer(0, 8'hA5, 1'b1, 0);
    step();
    // ACK_DELAY=3, entry held
    xfer(2, 8'h3C, 1'b0, 0);
    step();
    drain();

    // fill with out_ready low: 5th refused, then drain in order
    for (int i = 1; i <= 5; i++) xfer(0, 8'(i), 1'b0, 0);
    rdy[0] = 1'b1;
    repeat (5) step();
    rdy[0] = 1'b0;

    // full FIFO, pop frees a slot: ack deferred one edge
    for (int i = 0; i < 4; i++) xfer(0, 8'(8'h60 + i), 1'b0, 0);
    xfer(0, 8'h77, 1'b1, 0);
    drain();

    // protocol violations
    xfer(2, 8'h11, 1'b1, 1);
    xfer(0, 8'h22, 1'b1, 2);
    xfer(1, 8'h33, 1'b1, 3);
    for (int i = 0; i < 4; i++) xfer(0, 8'(8'h80 + i), 1'b0, 0);
    xfer(0, 8'h44, 1'b0, 4);

    // drop counter saturation
    repeat (256) xfer(0, 8'($urandom), 1'b0, 0);

    // reset in the middle of an ARM phase with 2 entries queued
    drain();
    xfer(2, 8'h01, 1'b0, 0);
    xfer(2, 8'h02, 1'b0, 0);
    dv[2] = 1'b1;
    dd[2] = 8'h5A;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdrop[i] = 0;
    end
    step();
    reset = 1'b1;
    step();
    step();
    dv[2] = 1'b0;
    step();
    xfer(2, 8'hC3, 1'b1, 0);
    step();

    // randomized legal traffic
    repeat (120) begin
      xfer($urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 3; i++) rdy[i] = 1'($urandom_range(0, 1));
        step();
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
